// File: rtl/sobel_raster_ctrl_if.sv
// -----------------------------------------------------------------------------
// sobel_raster_ctrl_if
//   Pixel-stream handshake plus the per-beat raster metadata that the frame
//   sequencer hands to the line buffers and kernel datapath.
//
//   Signals (named from the sequencer's point of view):
//     in_valid_i   upstream pixel valid
//     in_ready_o   upstream ready (sequencer in RUN and downstream ready)
//     ds_ready_i   downstream line buffer can accept
//     beat_o       a pixel was accepted on the previous cycle
//     beat_col_o   column of that pixel
//     beat_row_o   row of that pixel
//     win_valid_o  that pixel completes a full kernel window
//     sof_o        that pixel is (0,0)
//     eol_o        that pixel is the last of its line
//     eof_o        that pixel is the last of the frame
//
//   Modports: master = the sequencer, slave = stream source / metadata sink.
// -----------------------------------------------------------------------------
interface sobel_raster_ctrl_if #(
    parameter int COL_W_P = 10,
    parameter int ROW_W_P = 10
);
    logic               in_valid_i;
    logic               in_ready_o;
    logic               ds_ready_i;
    logic               beat_o;
    logic [COL_W_P-1:0] beat_col_o;
    logic [ROW_W_P-1:0] beat_row_o;
    logic               win_valid_o;
    logic               sof_o;
    logic               eol_o;
    logic               eof_o;

    modport master (
        input  in_valid_i,
        input  ds_ready_i,
        output in_ready_o,
        output beat_o,
        output beat_col_o,
        output beat_row_o,
        output win_valid_o,
        output sof_o,
        output eol_o,
        output eof_o
    );

    modport slave (
        output in_valid_i,
        output ds_ready_i,
        input  in_ready_o,
        input  beat_o,
        input  beat_col_o,
        input  beat_row_o,
        input  win_valid_o,
        input  sof_o,
        input  eol_o,
        input  eof_o
    );
endinterface

// File: rtl/sobel_raster_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_raster_ctrl
//   Frame sequencer for the Sobel pipeline. Gates the pixel stream with a
//   valid/ready handshake, tracks raster position with wrapping column/row
//   counters, and emits registered per-beat metadata one cycle after each
//   accepted pixel. A three-state FSM (IDLE/RUN/DONE) bounds each frame
//   between a start command and a one-cycle done pulse.
//
//   Ports:
//     clk_i    clock
//     rst_i    asynchronous active-high reset
//     start_i  begin a frame (honoured in IDLE only)
//     abort_i  cancel the frame and return to IDLE (highest priority)
//     busy_o   sequencer not in IDLE
//     done_o   one-cycle pulse, coincident with the final beat/eof
//     px       handshake + metadata bundle (master side)
// -----------------------------------------------------------------------------
module sobel_raster_ctrl #(
    parameter int IMG_W_P  = 640,
    parameter int IMG_H_P  = 480,
    parameter int COL_W_P  = 10,
    parameter int ROW_W_P  = 10,
    parameter int KERNEL_P = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    sobel_raster_ctrl_if.master px
);

    localparam logic [COL_W_P-1:0] COL_LAST = COL_W_P'(IMG_W_P - 1);
    localparam logic [ROW_W_P-1:0] ROW_LAST = ROW_W_P'(IMG_H_P - 1);
    localparam logic [COL_W_P-1:0] COL_WIN  = COL_W_P'(KERNEL_P - 1);
    localparam logic [ROW_W_P-1:0] ROW_WIN  = ROW_W_P'(KERNEL_P - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W_P-1:0] col_q, col_d;
    logic [ROW_W_P-1:0] row_q, row_d;

    logic               beat_q, beat_d;
    logic [COL_W_P-1:0] beat_col_q, beat_col_d;
    logic [ROW_W_P-1:0] beat_row_q, beat_row_d;
    logic               win_q, win_d;
    logic               sof_q, sof_d;
    logic               eol_q, eol_d;
    logic               eof_q, eof_d;

    logic               in_ready;
    logic               hs;

    // Toggle-carry increment: a bit flips when every lower bit is set.
    function automatic logic [COL_W_P-1:0] col_inc(input logic [COL_W_P-1:0] v);
        logic [COL_W_P-1:0] r;
        logic               carry;
        carry = 1'b1;
        for (int i = 0; i < COL_W_P; i++) begin
            r[i]  = v[i] ^ carry;
            carry = carry & v[i];
        end
        return r;
    endfunction

    function automatic logic [ROW_W_P-1:0] row_inc(input logic [ROW_W_P-1:0] v);
        logic [ROW_W_P-1:0] r;
        logic               carry;
        carry = 1'b1;
        for (int i = 0; i < ROW_W_P; i++) begin
            r[i]  = v[i] ^ carry;
            carry = carry & v[i];
        end
        return r;
    endfunction

    // Ready depends only on state and downstream, never on in_valid_i,
    // so upstream may legally wait for ready before raising valid.
    assign in_ready = (state_q == S_RUN) & px.ds_ready_i;
    assign hs       = px.in_valid_i & in_ready;

    // FSM next state and raster counters
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (hs) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_inc(row_q);
                        end
                    end else begin
                        col_d = col_inc(col_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in IDLE.
        if (abort_i) begin
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
        end
    end

    // Metadata for the pixel accepted this cycle; a beat coinciding with
    // abort is dropped. Coordinates hold their last value between beats.
    always_comb begin
        beat_d     = hs & ~abort_i;
        beat_col_d = beat_col_q;
        beat_row_d = beat_row_q;
        win_d      = 1'b0;
        sof_d      = 1'b0;
        eol_d      = 1'b0;
        eof_d      = 1'b0;
        if (beat_d) begin
            beat_col_d = col_q;
            beat_row_d = row_q;
            win_d      = (col_q >= COL_WIN) & (row_q >= ROW_WIN);
            sof_d      = (col_q == '0) & (row_q == '0);
            eol_d      = (col_q == COL_LAST);
            eof_d      = (col_q == COL_LAST) & (row_q == ROW_LAST);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            beat_q     <= 1'b0;
            beat_col_q <= '0;
            beat_row_q <= '0;
            win_q      <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            beat_q     <= beat_d;
            beat_col_q <= beat_col_d;
            beat_row_q <= beat_row_d;
            win_q      <= win_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
        end
    end

    assign px.in_ready_o  = in_ready;
    assign px.beat_o      = beat_q;
    assign px.beat_col_o  = beat_col_q;
    assign px.beat_row_o  = beat_row_q;
    assign px.win_valid_o = win_q;
    assign px.sof_o       = sof_q;
    assign px.eol_o       = eol_q;
    assign px.eof_o       = eof_q;

    // DONE is entered on the edge that registers the final beat, so the
    // done pulse lines up with eof without an extra register.
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_sobel_raster_ctrl.sv
module tb_sobel_raster_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int K = 3;

    logic clk;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;

    sobel_raster_ctrl_if #(.COL_W_P(2), .ROW_W_P(2)) ifc ();

    sobel_raster_ctrl #(
        .IMG_W_P (W),
        .IMG_H_P (H),
        .COL_W_P (2),
        .ROW_W_P (2),
        .KERNEL_P(K)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .abort_i(abort),
        .busy_o (busy),
        .done_o (done),
        .px     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;
    int cyc;

    // Reference model: frame mode (0 idle, 1 running, 2 done) and count of
    // pixels accepted so far in the frame; coordinates come from idx % W, idx / W.
    int m_mode;
    int m_idx;

    logic        exp_beat, exp_win, exp_sof, exp_eol, exp_eof, exp_busy, exp_done, exp_ready;
    logic [1:0]  exp_col, exp_row;
    logic [10:0] exp_vec;
    logic        obs_ready;
    logic [10:0] obs_vec;

    assign obs_vec = {ifc.beat_o, ifc.beat_col_o, ifc.beat_row_o, ifc.win_valid_o,
                      ifc.sof_o, ifc.eol_o, ifc.eof_o, busy, done};

    task automatic reset_model();
        m_mode   = 0;
        m_idx    = 0;
        exp_beat = 0; exp_win = 0; exp_sof = 0; exp_eol = 0; exp_eof = 0;
        exp_busy = 0; exp_done = 0; exp_ready = 0;
        exp_col  = '0; exp_row = '0;
        exp_vec  = '0;
    endtask

    // Drive one cycle of inputs (from a negedge), advance the model, and
    // return at the following negedge with outputs settled.
    task automatic step(input logic st, input logic ab, input logic vl, input logic ds);
        int c, r;
        logic acc;
        start          = st;
        abort          = ab;
        ifc.in_valid_i = vl;
        ifc.ds_ready_i = ds;
        #1;
        obs_ready = ifc.in_ready_o;
        exp_ready = (m_mode == 1) && ds;
        acc       = exp_ready && vl && !ab;
        exp_beat = 0; exp_win = 0; exp_sof = 0; exp_eol = 0; exp_eof = 0;
        if (ab) begin
            m_mode = 0;
            m_idx  = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_mode = 1;
                m_idx  = 0;
            end
        end else if (m_mode == 1) begin
            if (acc) begin
                c        = m_idx % W;
                r        = m_idx / W;
                exp_beat = 1;
                exp_col  = 2'(c);
                exp_row  = 2'(r);
                exp_win  = (c >= K - 1) && (r >= K - 1);
                exp_sof  = (m_idx == 0);
                exp_eol  = (c == W - 1);
                exp_eof  = (m_idx == W * H - 1);
                m_idx++;
                if (m_idx == W * H) begin
                    m_mode = 2;
                    m_idx  = 0;
                end
            end
        end else begin
            m_mode = 0;
        end
        exp_busy = (m_mode != 0);
        exp_done = (m_mode == 2);
        exp_vec  = {exp_beat, exp_col, exp_row, exp_win, exp_sof, exp_eol, exp_eof, exp_busy, exp_done};
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; abort = 0; ifc.in_valid_i = 0; ifc.ds_ready_i = 0;
        reset_model();
        repeat (2) @(negedge clk);
        compared++;
        if (obs_vec !== 11'd0 || ifc.in_ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: outputs %h ready %b, required 000 ready 0", obs_vec, ifc.in_ready_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        int nbeat = 0, nwin = 0, neol = 0, ndone = 0, nsof = 0, neof_done = 0;
        step(1, 0, 1, 1);
        compared++;
        if (obs_vec !== exp_vec) begin
            mismatched++;
            $display("FAIL full_frame_start cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 1, 1);
            compared++;
            if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
                mismatched++;
                $display("FAIL full_frame cyc %0d: got %h/%b want %h/%b", cyc, obs_vec, obs_ready, exp_vec, exp_ready);
            end
            nbeat += int'(ifc.beat_o);
            nwin  += int'(ifc.win_valid_o);
            neol  += int'(ifc.eol_o);
            nsof  += int'(ifc.sof_o);
            ndone += int'(done);
            neof_done += int'(done & ifc.eof_o);
        end
        compared++;
        if (nbeat !== 12 || nsof !== 1 || neol !== 3) begin
            mismatched++;
            $display("FAIL frame_counts: beats %0d sof %0d eol %0d, required 12 1 3", nbeat, nsof, neol);
        end
        compared++;
        if (nwin !== 2) begin
            mismatched++;
            $display("FAIL win_valid_count: got %0d want 2", nwin);
        end
        compared++;
        if (ndone !== 1 || neof_done !== 1) begin
            mismatched++;
            $display("FAIL done_pulse: done %0d done&eof %0d, required 1 1", ndone, neof_done);
        end
    endtask

    task automatic test_backpressure();
        step(1, 0, 1, 1);
        for (int i = 0; i < 26; i++) begin
            step(0, 0, 1, (i < 16) ? ((i % 2) == 0) : 1'b1);
            compared++;
            if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
                mismatched++;
                $display("FAIL backpressure cyc %0d: got %h/%b want %h/%b", cyc, obs_vec, obs_ready, exp_vec, exp_ready);
            end
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL backpressure_end: busy %b want 0", busy);
        end
    endtask

    task automatic test_abort();
        step(1, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        compared++;
        if (obs_vec !== exp_vec || obs_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_cycle: got %h/%b want %h/1", obs_vec, obs_ready, exp_vec);
        end
        compared++;
        if (ifc.beat_o !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_drop: beat %b done %b busy %b, required 0 0 0", ifc.beat_o, done, busy);
        end
        step(1, 1, 1, 1);
        compared++;
        if (obs_vec !== exp_vec || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL start_abort_idle: got %h want %h", obs_vec, exp_vec);
        end
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        compared++;
        if (ifc.sof_o !== 1'b1 || ifc.beat_col_o !== 2'd0 || ifc.beat_row_o !== 2'd0 || obs_vec !== exp_vec) begin
            mismatched++;
            $display("FAIL abort_restart: sof %b col %0d row %0d, required 1 0 0", ifc.sof_o, ifc.beat_col_o, ifc.beat_row_o);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_start_held();
        int ndone = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 1, 1);
            compared++;
            if (obs_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL start_held cyc %0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
            ndone += int'(done);
        end
        compared++;
        if (ndone !== 2) begin
            mismatched++;
            $display("FAIL start_held_frames: done pulses %0d want 2", ndone);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_async_reset();
        step(1, 0, 1, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (obs_vec !== 11'd0 || ifc.in_ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: outputs %h ready %b, required 000 ready 0", obs_vec, ifc.in_ready_o);
        end
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 1, 1);
        step(0, 0, 1, 1);
        compared++;
        if (ifc.sof_o !== 1'b1 || ifc.beat_col_o !== 2'd0 || ifc.beat_row_o !== 2'd0 || obs_vec !== exp_vec) begin
            mismatched++;
            $display("FAIL reset_restart: got %h want %h", obs_vec, exp_vec);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) == 0, ($urandom % 40) == 0, ($urandom % 3) != 0, ($urandom % 4) != 0);
            compared++;
            if (obs_vec !== exp_vec || obs_ready !== exp_ready) begin
                mismatched++;
                $display("FAIL random cyc %0d: got %h/%b want %h/%b", cyc, obs_vec, obs_ready, exp_vec, exp_ready);
            end
        end
        step(0, 1, 0, 0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_abort();
        test_start_held();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sobel_raster_ctrl.md
Name: sobel_raster_ctrl

Overview:
Frame sequencer for the Sobel pipeline. It gates a pixel stream with a valid/ready handshake and tracks raster position with column and row counters that wrap per line and per frame. For every accepted pixel it emits registered per-beat metadata: coordinates, 3x3 window-valid, and start/end-of-line/frame flags. The line buffers and the kernel datapath consume this metadata. A small FSM bounds each frame between a start command and a done pulse.

Parameters:
IMG_W_P, 640, pixels per line (>= KERNEL_P)
IMG_H_P, 480, lines per frame (>= KERNEL_P)
COL_W_P, 10, column counter width (2**COL_W_P >= IMG_W_P)
ROW_W_P, 10, row counter width (2**ROW_W_P >= IMG_H_P)
KERNEL_P, 3, kernel size; window valid once col, row >= KERNEL_P-1

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
start_i  in  1  begin frame (sampled in IDLE only)
abort_i  in  1  cancel frame, return to IDLE
in_valid_i  in  1  upstream pixel valid
in_ready_o  out  1  upstream ready = (state==RUN) & ds_ready_i
ds_ready_i  in  1  downstream (line buffer) can accept
beat_o  out  1  registered: a pixel was accepted last cycle
beat_col_o  out  COL_W_P  column of that pixel
beat_row_o  out  ROW_W_P  row of that pixel
win_valid_o  out  1  that pixel completes a full KERNEL_P x KERNEL_P window
sof_o  out  1  that pixel is (0,0)
eol_o  out  1  that pixel is col IMG_W_P-1
eof_o  out  1  that pixel is (IMG_W_P-1, IMG_H_P-1)
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset (async assert, sync release): state=IDLE; col/row counters 0; all outputs 0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready_o=0. start_i=1 -> RUN next cycle, counters cleared.
- RUN: handshake hs = in_valid_i & in_ready_o. in_ready_o is combinational from state and ds_ready_i, with no dependence on in_valid_i.
- On hs: col increments. At col==IMG_W_P-1, col wraps to 0 and row increments. At row==IMG_H_P-1 with col==IMG_W_P-1, row wraps to 0 and state moves to DONE.
- No hs: counters hold, and beat_o=0 on the next cycle.
- Metadata latency is 1 cycle: the pixel accepted in cycle N has beat_o=1 with its pre-increment col/row and flags at N+1. Otherwise beat_o and all flags are 0. beat_col_o/beat_row_o hold their last value.
- win_valid_o = (col >= KERNEL_P-1) & (row >= KERNEL_P-1) for the accepted pixel.
- DONE: lasts exactly one cycle with done_o=1 and in_ready_o=0, then IDLE.
  - done_o asserts in the same cycle as the final beat_o/eof_o.
- start_i is ignored in RUN and DONE; a new frame needs start_i in IDLE.
- abort_i has priority over hs and start_i in any state:
  - next state IDLE; counters cleared; done_o not pulsed.
  - A beat accepted in the same cycle as abort is dropped: no beat_o.
- Simultaneous start_i and abort_i in IDLE: stay IDLE.
- Backpressure: ds_ready_i=0 stalls acceptance, and counters hold with no metadata. in_valid_i may drop between beats; no bubbles are inserted.
- Async rst_i mid-frame: immediate return to reset values. The partial frame is discarded and there is no done pulse.
- Counters use the same toggle-carry style as the team counter, or may instantiate it, but wrap at IMG_W_P/IMG_H_P rather than at a power of two.

Test Plan:
- IMG_W_P=4, IMG_H_P=3, in_valid_i and ds_ready_i held high, start_i pulse -> 12 beats in consecutive cycles.
  - sof_o on beat 0; eol_o on beats 3, 7, 11; eof_o and done_o on beat 11; busy_o low 1 cycle after done_o.
- Same configuration, check win_valid_o -> high only for (2,2) and (3,2), i.e. beats 10 and 11.
- ds_ready_i toggled 1,0,1,0 with in_valid_i high -> in_ready_o follows ds_ready_i; beats only after ready-high cycles; coordinates contiguous with no skips or duplicates.
- abort_i asserted at beat 5 with hs in the same cycle -> no beat_o for that pixel, no done_o, IDLE next cycle.
  - Next start_i restarts at (0,0) with sof_o.
- start_i held high through RUN and DONE -> a single frame only. A second frame begins only from the IDLE cycle after done_o, with start_i high there.
- rst_i asserted asynchronously mid-cycle during row 1 -> all outputs 0 immediately. After release, start_i gives sof_o at (0,0).
